// File: rtl/bank_stream_reader.sv
// bank_stream_reader: walks the enabled channels of a banked sample RAM after an
// acquisition-complete falling edge and streams a header plus the data words of
// each channel over a valid/ready interface.
// Optional build macro BANK_STREAM_READER_CSUM_EN appends an XOR checksum word
// after the data of every channel with a non-zero length.
module bank_stream_reader #(
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned VCH_PER_BANK = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LEN_W        = 8,
  localparam int unsigned NUM_CH      = NUM_BANKS * VCH_PER_BANK,
  localparam int unsigned VCH_W       = (VCH_PER_BANK > 1) ? $clog2(VCH_PER_BANK) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_complite,
  input  logic [NUM_CH-1:0]             i_chn_mask,
  output logic [VCH_W-1:0]              o_rd_vchn,
  input  logic [NUM_BANKS*LEN_W-1:0]    i_data_len,
  input  logic [NUM_BANKS*DATA_W-1:0]   i_rd_data,
  output logic [LEN_W-1:0]              o_rd_addr,
  output logic [DATA_W-1:0]             o_out_data,
  output logic                          o_out_vld,
  input  logic                          i_out_rdy,
  output logic                          o_busy,
  output logic                          o_overrun
);

  // Channel counter runs one past the last channel to mark end of frame.
  localparam int unsigned CH_W  = $clog2(NUM_CH + 1);
  localparam int unsigned SEQ_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEXT,
    S_HDR,
    S_RADDR,
    S_RWAIT,
    S_DATA
`ifdef BANK_STREAM_READER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                cpl_q;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    addr_d;
  logic [VCH_W-1:0]    vchn_d;
  logic [DATA_W-1:0]   data_d;
  logic                vld_d;
  logic                busy_d;
  logic                overrun_d;
  logic                start_c;
`ifdef BANK_STREAM_READER_CSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  assign start_c = cpl_q & ~i_complite;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cpl_q      <= 1'b0;
      seq_q      <= '0;
      ch_q       <= '0;
      mask_q     <= '0;
      len_q      <= '0;
      o_rd_addr  <= '0;
      o_rd_vchn  <= '0;
      o_out_data <= '0;
      o_out_vld  <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
`ifdef BANK_STREAM_READER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cpl_q      <= i_complite;
      seq_q      <= seq_d;
      ch_q       <= ch_d;
      mask_q     <= mask_d;
      len_q      <= len_d;
      o_rd_addr  <= addr_d;
      o_rd_vchn  <= vchn_d;
      o_out_data <= data_d;
      o_out_vld  <= vld_d;
      o_busy     <= busy_d;
      o_overrun  <= overrun_d;
`ifdef BANK_STREAM_READER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    len_d     = len_q;
    addr_d    = o_rd_addr;
    vchn_d    = o_rd_vchn;
    data_d    = o_out_data;
`ifdef BANK_STREAM_READER_CSUM_EN
    csum_d    = csum_q;
`endif
    overrun_d = start_c && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          mask_d  = i_chn_mask;
          seq_d   = seq_q + SEQ_W'(1);
          ch_d    = '0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (ch_q == CH_W'(NUM_CH)) begin
          state_d = S_IDLE;
        end else if (|(mask_q & (NUM_CH'(1) << ch_q))) begin
          len_d   = LEN_W'(i_data_len >> (LEN_W * (32'(ch_q) / VCH_PER_BANK)));
          addr_d  = '0;
          vchn_d  = VCH_W'(32'(ch_q) % VCH_PER_BANK);
          data_d  = '0;
          data_d[31:0] = {seq_q, 8'(ch_q), 16'(len_d)};
`ifdef BANK_STREAM_READER_CSUM_EN
          csum_d  = '0;
`endif
          state_d = S_HDR;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      S_HDR: begin
        if (i_out_rdy) begin
          if (len_q != '0) begin
            state_d = S_RADDR;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = S_NEXT;
          end
        end
      end
      S_RADDR: begin
        state_d = S_RWAIT;
      end
      // RAM output for the address presented in RADDR is valid here.
      S_RWAIT: begin
        data_d  = DATA_W'(i_rd_data >> (DATA_W * (32'(ch_q) / VCH_PER_BANK)));
        state_d = S_DATA;
      end
      S_DATA: begin
        if (i_out_rdy) begin
`ifdef BANK_STREAM_READER_CSUM_EN
          csum_d = csum_q ^ o_out_data;
`endif
          // len_q >= 1 here, so len_q-1 cannot underflow and addr never wraps.
          if (o_rd_addr < len_q - LEN_W'(1)) begin
            addr_d  = o_rd_addr + LEN_W'(1);
            state_d = S_RADDR;
          end else begin
`ifdef BANK_STREAM_READER_CSUM_EN
            data_d  = csum_q ^ o_out_data;
            state_d = S_CSUM;
`else
            ch_d    = ch_q + CH_W'(1);
            state_d = S_NEXT;
`endif
          end
        end
      end
`ifdef BANK_STREAM_READER_CSUM_EN
      S_CSUM: begin
        if (i_out_rdy) begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_NEXT;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    vld_d = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef BANK_STREAM_READER_CSUM_EN
            || (state_d == S_CSUM)
`endif
            ;
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_bank_stream_reader.sv
// Directed bench for bank_stream_reader: models the banked RAM, collects the
// accepted stream words and compares them against hand-derived frames.
module tb_bank_stream_reader;

  localparam int NB  = 4;
  localparam int VPB = 4;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int NCH = NB * VPB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_complite = 1'b0;
  logic [NCH-1:0]    i_chn_mask = '0;
  logic [1:0]        o_rd_vchn;
  logic [NB*LW-1:0]  i_data_len = '0;
  logic [NB*DW-1:0]  i_rd_data;
  logic [LW-1:0]     o_rd_addr;
  logic [DW-1:0]     o_out_data;
  logic              o_out_vld;
  logic              i_out_rdy = 1'b1;
  logic              o_busy;
  logic              o_overrun;

  int          total = 0;
  int          bad = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  int          rp = 0;
  int          stab_err = 0;
  int          ovr_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = '0;

  bank_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_complite (i_complite),
    .i_chn_mask (i_chn_mask),
    .o_rd_vchn  (o_rd_vchn),
    .i_data_len (i_data_len),
    .i_rd_data  (i_rd_data),
    .o_rd_addr  (o_rd_addr),
    .o_out_data (o_out_data),
    .o_out_vld  (o_out_vld),
    .i_out_rdy  (i_out_rdy),
    .o_busy     (o_busy),
    .o_overrun  (o_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input int c, input int a);
    return {8'hD0 ^ 8'(a * 7), 8'(c), 8'h5A, 8'(a)};
  endfunction

  // Banked RAM model with one cycle of read latency.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      i_rd_data[b*DW +: DW] <= ram_word(b * VPB + int'(o_rd_vchn), int'(o_rd_addr));
  end

  // Stream monitor: records accepted words, hold stability, overrun pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_out_vld && i_out_rdy) got.push_back(o_out_data);
      if (hold_pend && (o_out_vld !== 1'b1 || o_out_data !== hold_data)) stab_err++;
      hold_pend = o_out_vld && !i_out_rdy;
      hold_data = o_out_data;
      if (o_overrun) ovr_cnt++;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_ch(input int seq, input int c, input int len);
    logic [31:0] x = '0;
    logic [31:0] w;
    exp_q.push_back({8'(seq), 8'(c), 16'(len)});
    for (int a = 0; a < len; a++) begin
      w = ram_word(c, a);
      x = x ^ w;
      exp_q.push_back(w);
    end
`ifdef BANK_STREAM_READER_CSUM_EN
    if (len > 0) exp_q.push_back(x);
`endif
  endtask

  task automatic cmp_stream(input string tag);
    int n = got.size() - rp;
    chk({tag, "_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(got[rp + i]), 64'(exp_q[i]));
    rp = got.size();
    exp_q.delete();
  endtask

  task automatic start_frame(input string tag);
    i_complite = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_complite = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_busy_rise"}, 64'(o_busy), 64'(1));
  endtask

  task automatic wait_done(input int bound, input string tag);
    int n = 0;
    while (o_busy !== 1'b0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, 64'(o_busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int ovr0;
    int gsz;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 64'(o_out_vld), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_data", 64'(o_out_data), 64'(0));
    chk("rst_addr", 64'(o_rd_addr), 64'(0));
    chk("rst_vchn", 64'(o_rd_vchn), 64'(0));
    chk("rst_ovr", 64'(o_overrun), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All channels, length 3, ready held high, seq 1.
    i_data_len = {8'd3, 8'd3, 8'd3, 8'd3};
    i_chn_mask = 16'hFFFF;
    start_frame("all3");
    wait_done(2000, "all3");
    for (int c = 0; c < NCH; c++) exp_ch(1, c, 3);
    cmp_stream("all3");
    chk("all3_vld_idle", 64'(o_out_vld), 64'(0));

    // Single enabled channel with zero length: header only, seq 2.
    i_data_len = {8'd3, 8'd3, 8'd3, 8'd0};
    i_chn_mask = 16'h0001;
    start_frame("zlen");
    wait_done(200, "zlen");
    exp_q.push_back(32'h0200_0000);
    cmp_stream("zlen");

    // Random backpressure on channels 5 and 6 (bank 1), seq 3.
    i_data_len = {8'd1, 8'd2, 8'd4, 8'd7};
    i_chn_mask = 16'h0060;
    start_frame("bp");
    n = 0;
    while (o_busy && n < 2000) begin
      @(posedge clk);
      #1 i_out_rdy = 1'($urandom_range(0, 1));
      n++;
    end
    i_out_rdy = 1'b1;
    wait_done(200, "bp");
    exp_ch(3, 5, 4);
    exp_ch(3, 6, 4);
    cmp_stream("bp");
    chk("bp_hold_stable", 64'(stab_err), 64'(0));

    // Second falling edge while busy: one overrun pulse, frame unaffected, seq 4.
    i_data_len = {8'd2, 8'd2, 8'd2, 8'd2};
    i_chn_mask = 16'hFFFF;
    ovr0 = ovr_cnt;
    start_frame("ovr");
    repeat (20) @(posedge clk);
    #1 i_complite = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_complite = 1'b0;
    wait_done(2000, "ovr");
    chk("ovr_pulses", 64'(ovr_cnt - ovr0), 64'(1));
    for (int c = 0; c < NCH; c++) exp_ch(4, c, 2);
    cmp_stream("ovr");

    // Following frame uses seq 5: last channel only.
    i_data_len = {8'd1, 8'd0, 8'd0, 8'd0};
    i_chn_mask = 16'h8000;
    start_frame("after_ovr");
    wait_done(200, "after_ovr");
    exp_ch(5, 15, 1);
    cmp_stream("after_ovr");

    // Reset in the middle of a frame.
    i_data_len = {8'd3, 8'd3, 8'd3, 8'd3};
    i_chn_mask = 16'hFFFF;
    start_frame("midrst");
    n = 0;
    while (got.size() < rp + 6 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midrst_reached", 64'(got.size() >= rp + 6), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_vld", 64'(o_out_vld), 64'(0));
    chk("midrst_busy", 64'(o_busy), 64'(0));
    chk("midrst_data", 64'(o_out_data), 64'(0));
    chk("midrst_addr", 64'(o_rd_addr), 64'(0));
    chk("midrst_vchn", 64'(o_rd_vchn), 64'(0));
    gsz = got.size();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_quiet", 64'(got.size()), 64'(gsz));
    chk("midrst_busy_after", 64'(o_busy), 64'(0));
    rp = got.size();

    // Fresh frame after reset restarts at seq 1.
    i_data_len = {8'd3, 8'd3, 8'd3, 8'd1};
    i_chn_mask = 16'h0003;
    start_frame("postrst");
    wait_done(200, "postrst");
    exp_ch(1, 0, 1);
    exp_ch(1, 1, 1);
    cmp_stream("postrst");

    // Maximum length 255 on channel 4, seq 2.
    i_data_len = {8'd0, 8'd0, 8'd255, 8'd0};
    i_chn_mask = 16'h0010;
    start_frame("maxlen");
    wait_done(5000, "maxlen");
    exp_ch(2, 4, 255);
    cmp_stream("maxlen");

    chk("final_hold_stable", 64'(stab_err), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
